// File: rtl/vga_sync_gen.sv
// VGA raster timing generator running on SYSCLK, paced by rising edges of the
// SYSCLK-synchronous pixel clock PCK. Decoded sync/enable outputs lag HCNT/VCNT by one cycle.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             SYSCLK,
  input  logic             RSTN,
  input  logic             PCK,
  output logic [CNT_W-1:0] HCNT,
  output logic [CNT_W-1:0] VCNT,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DISP_EN,
  output logic             LINE_START,
  output logic             FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             r_pck_d;
  logic             r_tick_q;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_disp_en;
  logic             r_line_start;
  logic             r_frame_start;

  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_hs_act;
  logic w_vs_act;
  logic w_visible;
  logic w_line_wrap;
  logic w_frame_wrap;

  // pck_d resets high so a PCK already high at reset release is not taken as an edge
  assign w_tick   = PCK & ~r_pck_d;
  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pck_d  <= 1'b1;
      r_tick_q <= 1'b0;
    end else begin
      r_pck_d  <= PCK;
      r_tick_q <= w_tick;
    end
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
      end else begin
        r_hcnt <= r_hcnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_hs_act     = (r_hcnt >= HS_BEG) && (r_hcnt <= HS_END);
    w_vs_act     = (r_vcnt >= VS_BEG) && (r_vcnt <= VS_END);
    w_visible    = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    // a wrap is only reported when the previous cycle's tick produced it, not after reset
    w_line_wrap  = r_tick_q && (r_hcnt == '0);
    w_frame_wrap = w_line_wrap && (r_vcnt == '0);
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_disp_en     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_disp_en     <= w_visible;
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign HCNT        = r_hcnt;
  assign VCNT        = r_vcnt;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign DISP_EN     = r_disp_en;
  assign LINE_START  = r_line_start;
  assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance and a tiny active-high-sync instance
// share SYSCLK/RSTN/PCK and are checked every cycle against a pixel-index reference model.
module tb_vga_sync_gen;

  logic SYSCLK;
  logic RSTN;
  logic PCK;

  logic [9:0] hcnt0, vcnt0;
  logic       hs0, vs0, de0, ls0, fs0;
  logic [3:0] hcnt1, vcnt1;
  logic       hs1, vs1, de1, ls1, fs1;

  vga_sync_gen u_big (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .PCK(PCK),
    .HCNT(hcnt0), .VCNT(vcnt0), .HSYNC(hs0), .VSYNC(vs0),
    .DISP_EN(de0), .LINE_START(ls0), .FRAME_START(fs0)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) u_small (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .PCK(PCK),
    .HCNT(hcnt1), .VCNT(vcnt1), .HSYNC(hs1), .VSYNC(vs1),
    .DISP_EN(de1), .LINE_START(ls1), .FRAME_START(fs1)
  );

  initial begin
    SYSCLK = 1'b0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: each instance is a pixel index p in 0..HT*VT-1; h = p % HT, v = p / HT.
  int HT[2]   = '{800, 15};
  int VT[2]   = '{525, 11};
  int HSB[2]  = '{656, 10};
  int HSE[2]  = '{751, 12};
  int VSB[2]  = '{490, 7};
  int VSE[2]  = '{491, 8};
  int HACT[2] = '{640, 8};
  int VACT[2] = '{480, 6};
  bit POL[2]  = '{1'b0, 1'b1};

  int m_p[2];
  bit m_pck_d;
  bit m_ltick;
  bit e_hs[2], e_vs[2], e_de[2], e_ls[2], e_fs[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("big HCNT", 32'(hcnt0), m_p[0] % HT[0]);
    chk("big VCNT", 32'(vcnt0), m_p[0] / HT[0]);
    chk("big HSYNC", 32'(hs0), 32'(e_hs[0]));
    chk("big VSYNC", 32'(vs0), 32'(e_vs[0]));
    chk("big DISP_EN", 32'(de0), 32'(e_de[0]));
    chk("big LINE_START", 32'(ls0), 32'(e_ls[0]));
    chk("big FRAME_START", 32'(fs0), 32'(e_fs[0]));
    chk("small HCNT", 32'(hcnt1), m_p[1] % HT[1]);
    chk("small VCNT", 32'(vcnt1), m_p[1] / HT[1]);
    chk("small HSYNC", 32'(hs1), 32'(e_hs[1]));
    chk("small VSYNC", 32'(vs1), 32'(e_vs[1]));
    chk("small DISP_EN", 32'(de1), 32'(e_de[1]));
    chk("small LINE_START", 32'(ls1), 32'(e_ls[1]));
    chk("small FRAME_START", 32'(fs1), 32'(e_fs[1]));
  endtask

  // Apply inputs, take one SYSCLK edge, advance the model, compare everything.
  task automatic step(input logic rstn_v, input logic pck_v);
    bit tick;
    int h, v;
    RSTN = rstn_v;
    PCK  = pck_v;
    @(posedge SYSCLK);
    #1;
    if (!rstn_v) begin
      m_pck_d = 1'b1;
      m_ltick = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_p[d]  = 0;
        e_hs[d] = !POL[d];
        e_vs[d] = !POL[d];
        e_de[d] = 1'b0;
        e_ls[d] = 1'b0;
        e_fs[d] = 1'b0;
      end
    end else begin
      tick = pck_v && !m_pck_d;
      for (int d = 0; d < 2; d++) begin
        h = m_p[d] % HT[d];
        v = m_p[d] / HT[d];
        e_hs[d] = (h >= HSB[d] && h <= HSE[d]) ? POL[d] : !POL[d];
        e_vs[d] = (v >= VSB[d] && v <= VSE[d]) ? POL[d] : !POL[d];
        e_de[d] = (h < HACT[d]) && (v < VACT[d]);
        e_ls[d] = m_ltick && (h == 0);
        e_fs[d] = m_ltick && (m_p[d] == 0);
        if (tick) m_p[d] = (m_p[d] + 1) % (HT[d] * VT[d]);
      end
      m_pck_d = pck_v;
      m_ltick = tick;
    end
    check_all();
  endtask

  typedef struct {
    bit rstn;
    bit pck;
    int h;
    bit de;
    bit hs;
    bit ls;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int last_ls, last_fs, n656, run, seen_ls, k, h_hold, s_hold;
    logic [9:0] prev_h;
    logic prev_hs;

    vecs[0] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};

    RSTN = 1'b0;
    PCK  = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Release point, before any SYSCLK edge has seen RSTN high
    RSTN = 1'b1;
    #1;
    chk("release HCNT", 32'(hcnt0), 0);
    chk("release VCNT", 32'(vcnt0), 0);
    chk("release DISP_EN", 32'(de0), 0);
    chk("release HSYNC", 32'(hs0), 1);
    chk("release VSYNC", 32'(vs0), 1);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rstn, vecs[i].pck);
      chk($sformatf("vec%0d HCNT", i), 32'(hcnt0), vecs[i].h);
      chk($sformatf("vec%0d DISP_EN", i), 32'(de0), 32'(vecs[i].de));
      chk($sformatf("vec%0d HSYNC", i), 32'(hs0), 32'(vecs[i].hs));
      chk($sformatf("vec%0d LINE_START", i), 32'(ls0), 32'(vecs[i].ls));
    end

    // PCK = SYSCLK/4 from a fresh reset
    step(1'b0, 1'b0);
    last_ls = -1; last_fs = -1; n656 = -100000; run = 0; seen_ls = 0;
    prev_h = hcnt0; prev_hs = hs0;
    for (int n = 0; n < 7000; n++) begin
      step(1'b1, (n % 4) >= 2);
      if (ls0) begin
        if (last_ls >= 0) chk("big line period", n - last_ls, 3200);
        last_ls = n;
        seen_ls++;
      end
      if (hcnt0 == 10'd656 && prev_h != 10'd656) n656 = n;
      if (!hs0 && prev_hs) chk("hsync start lag", n - n656, 1);
      if (!hs0) run++;
      else if (run > 0) begin
        chk("hsync width", run, 384);
        run = 0;
      end
      if (fs1) begin
        if (last_fs >= 0) chk("small frame period", n - last_fs, 660);
        last_fs = n;
      end
      prev_h = hcnt0;
      prev_hs = hs0;
    end
    chk("line pulses seen", 32'(seen_ls >= 2), 1);

    // Random PCK: rises are always at least two cycles apart
    for (int n = 0; n < 3000; n++) step(1'b1, 1'($urandom_range(0, 1)));

    // PCK stuck high: counters freeze
    step(1'b1, 1'b1);
    h_hold = m_p[0] % HT[0];
    s_hold = m_p[1] % HT[1];
    for (int n = 0; n < 40; n++) step(1'b1, 1'b1);
    chk("freeze big HCNT", 32'(hcnt0), h_hold);
    chk("freeze small HCNT", 32'(hcnt1), s_hold);
    for (int n = 0; n < 40; n++) step(1'b1, 1'b0);
    chk("freeze low big HCNT", 32'(hcnt0), h_hold);

    // Reset mid-line at HCNT=300
    k = 0;
    while ((m_p[0] % HT[0]) != 300 && k < 3000) begin
      step(1'b1, 1'(k % 2));
      k++;
    end
    chk("reached HCNT 300", 32'(hcnt0), 300);
    #2;
    RSTN = 1'b0;
    #1;
    chk("async rst HCNT", 32'(hcnt0), 0);
    chk("async rst VCNT", 32'(vcnt0), 0);
    chk("async rst DISP_EN", 32'(de0), 0);
    chk("async rst HSYNC", 32'(hs0), 1);
    chk("async rst small HSYNC", 32'(hs1), 0);
    chk("async rst small HCNT", 32'(hcnt1), 0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("post rst no tick", 32'(hcnt0), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("post rst first tick", 32'(hcnt0), 1);
    chk("post rst small first tick", 32'(hcnt1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
